// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory arbiter.
// Port indices double as the value of the arbiter's round-robin 'last' flag.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port
// that was not served last wins.
module rr_pick2
  import mips_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assign a default before any branch so combinational logic never infers a latch.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and the
// debug/DMA port, one registered command per access, round-robin on ties.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with one less than that.
  localparam logic [1:0] WAIT_INIT = 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [1:0]    cnt;
  logic          last;
  logic          port;
  logic [1:0]    gnt;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;

  rr_pick2 u_pick (
    .req  ({d_req, c_req}),
    .last (last),
    .gnt  (gnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (c_req || d_req) state_nxt = CMD;
      CMD:     state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      port      <= PORT_CPU;
      last      <= PORT_DBG;
      cnt       <= 2'd0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            port      <= gnt[PORT_DBG];
            cmd_we    <= gnt[PORT_DBG] ? d_we    : c_we;
            cmd_addr  <= gnt[PORT_DBG] ? d_addr  : c_addr;
            cmd_wdata <= gnt[PORT_DBG] ? d_wdata : c_wdata;
          end
        end
        CMD: begin
          last <= port;
          cnt  <= WAIT_INIT;
        end
        WAIT: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
        end
        RESP: begin
          if (port == PORT_DBG) d_rdata_q <= m_rdata;
          else                  c_rdata_q <= m_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_en  = (state == CMD);
    c_ack = (state == RESP) && (port == PORT_CPU);
    d_ack = (state == RESP) && (port == PORT_DBG);
    // Memory data is only valid during RESP: forward it with the ack, then
    // the captured copy holds it until that port's next ack.
    c_rdata = c_ack ? m_rdata : c_rdata_q;
    d_rdata = d_ack ? m_rdata : d_rdata_q;
  end

  assign m_we    = cmd_we;
  assign m_addr  = cmd_addr;
  assign m_wdata = cmd_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory of the MIPS datapath between the CPU load/store path and a debug/DMA port. The debug port is used for memory preload and dump. Each requester gets a req/ack handshake. The arbiter drives one registered command per access to the memory and returns read data with a one-cycle ack. Grants are round-robin, so a busy CPU cannot starve debug traffic, and debug traffic cannot starve the CPU.

## Interface
Parameters:
- AW, 32, word-address width
- DW, 32, data width
- MEM_LAT, 1, cycles from `m_en` to valid `m_rdata`; legal range 1..4

Ports:
- clk  in  1  system clock; all state on the rising edge
- res  in  1  reset, asynchronous, active-low (0 = reset)
- c_req  in  1  CPU access request
- c_we  in  1  CPU write enable
- c_addr  in  AW  CPU word address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  CPU access complete, one-cycle pulse
- c_rdata  out  DW  CPU read data, valid when `c_ack`=1
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata: debug port, identical to the CPU port
- m_en  out  1  memory command strobe
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data

## Operation
States:
- IDLE: samples requests.
- CMD: `m_en`=1 for exactly one cycle.
- WAIT: counts down MEM_LAT-1 cycles; skipped when MEM_LAT=1.
- RESP: pulses ack for the winning port.

Transitions:
- IDLE→CMD when `c_req` or `d_req` is high.
- CMD→WAIT, or CMD→RESP when MEM_LAT=1.
- WAIT→RESP when the counter reaches 0.
- RESP→IDLE unconditionally.

Arbitration:
- A single requester always wins.
- When both request in the same IDLE cycle, the port not served last wins.
- The `last` flag updates in CMD.
- After reset `last`=debug, so the CPU wins the first tie.

Command path:
- In IDLE, the winner's `we`/`addr`/`wdata` are latched into command registers.
- `m_*` outputs are driven only from those registers, never combinationally from the ports.

Response path:
- In RESP, `x_rdata` ← `m_rdata`, registered and held until the next ack to that port.
- Write accesses also return ack. Their `rdata` is the memory output and carries no meaning.

Requester rules:
- Hold req, we, addr and wdata stable until ack.
- Requests are not sampled in RESP. A req held high through ack is treated as a new access, granted in the next IDLE.
- Dropping req before ack is a protocol violation. The access still completes, and its ack is still driven.

Other rules:
- Addresses pass through unmodified; there is no range check.
- The arbiter keeps no other state.

## Timing
Reset:
- Asserting `res`=0 at any time forces IDLE, `last`=debug, and the WAIT counter to 0.
- All outputs go to 0 asynchronously, including `m_en`, both acks and both rdata registers.
- A command in flight is abandoned and no ack is issued. A write whose `m_en` was already sampled by memory may or may not have landed.

Latency for a request sampled in IDLE at edge N:
- `m_en` is high during cycle N+1.
- Ack is high during cycle N+1+MEM_LAT.
- The next IDLE sample happens at cycle N+2+MEM_LAT.
- Access period is MEM_LAT+2 cycles: 3 at the default.

Output constraints:
- `c_ack` and `d_ack` are never high in the same cycle.
- `m_en` is never high for two consecutive cycles.

## Structure
- Package `mips_pkg`:
  - `arb_state_t` enum (IDLE/CMD/WAIT/RESP)
  - port index constants `PORT_CPU`=0 and `PORT_DBG`=1
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs: `req[1:0]` and `last`. Output: one-hot `gnt[1:0]`.
- The FSM, command registers and response registers stay in `dmem_arbiter`.

## Test plan
All scenarios use MEM_LAT=1 unless stated otherwise.
- CPU write, `addr`=5, `wdata`=32'hDEAD_BEEF → `m_en`/`m_we` high for one cycle with `m_addr`=5; `c_ack` two cycles after sample. A following CPU read of `addr`=5 → `c_rdata`=32'hDEAD_BEEF with `c_ack`.
- `c_req` and `d_req` both held high for 12 cycles after reset → grant order C,D,C,D. Exactly 4 acks, alternating, one every 3 cycles; `d_ack` never high together with `c_ack`.
- Debug preload of words 0..49 with value i*3, then CPU reads of 0..49 → each `c_rdata` equals i*3.
- MEM_LAT=3, single debug read → `d_ack` 4 cycles after the sample edge; `m_en` high for exactly one cycle.
- `res` driven low in the cycle after `m_en` → all outputs 0 immediately; no ack. After release, a pending `c_req` is granted with CPU priority on a tie.
- `c_req` dropped in CMD → `c_ack` still pulses once; the arbiter then returns to IDLE with no further `m_en`.
